// File: rtl/pxl_stream_tx.sv
// Streams a D x D frame from a synchronous single-port RAM in raster order
// as a valid-qualified, no-backpressure pixel stream with sof/eol/eof framing.
module pxl_stream_tx #(
    parameter int D          = 299,
    parameter int data_width = 32,
    parameter int ADDR_W     = 17,
    parameter int GAP        = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [data_width-1:0] mem_rdata,
    output logic                  valid_out,
    output logic [data_width-1:0] pxl_out,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_o
);

    // Stream contract: valid_out qualifies pxl_out and the flags for one cycle;
    // there is no ready, so the consumer must accept every valid beat.
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_DRAIN} state_t;

    localparam int              CW       = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(D - 1);
    localparam int              GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [CW-1:0]       row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [GW-1:0]       gap_q, gap_d;

    logic                v1_q, sof1_q, eol1_q, eof1_q;
    logic                vo_q, sof_q, eol_q, eof_q, done_q;
    logic [data_width-1:0] pxl_q;

    logic issue;
    logic row_end;
    logic last_pix;

    assign issue    = (state_q == S_STREAM) && !pause;
    assign row_end  = (col_q == LAST_IDX);
    assign last_pix = row_end && (row_q == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (issue && last_pix) begin
                    state_d = S_DRAIN;
                end else if (issue && row_end && (GAP > 0)) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_STREAM;
            end
            S_DRAIN: begin
                // The eof beat is on the output this cycle; nothing else is in flight.
                if (eof_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = issue;
        mem_addr  = addr_q;
        busy      = (state_q != S_IDLE);
        valid_out = vo_q;
        pxl_out   = pxl_q;
        sof       = sof_q;
        eol       = eol_q;
        eof       = eof_q;
        done      = done_q;
        state_o   = state_q;
    end

    // Address runs alongside row/col so no multiplier is needed; it wraps to 0
    // on the final read so the next frame starts from a clean origin.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        gap_d  = gap_q;
        if ((state_q == S_IDLE) && start) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end
        if (issue) begin
            gap_d = '0;
            if (last_pix) begin
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
            end else if (row_end) begin
                col_d  = '0;
                row_d  = row_q + CW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                col_d  = col_q + CW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (state_q == S_GAP) begin
            gap_d = gap_q + GW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            gap_q  <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            gap_q  <= gap_d;
        end
    end

    // Stage 1 tracks the RAM read latency, stage 2 registers the data beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q   <= 1'b0;
            sof1_q <= 1'b0;
            eol1_q <= 1'b0;
            eof1_q <= 1'b0;
            vo_q   <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            eof_q  <= 1'b0;
            pxl_q  <= '0;
            done_q <= 1'b0;
        end else begin
            v1_q   <= issue;
            sof1_q <= issue && (col_q == '0) && (row_q == '0);
            eol1_q <= issue && row_end;
            eof1_q <= issue && last_pix;
            vo_q   <= v1_q;
            sof_q  <= sof1_q;
            eol_q  <= eol1_q;
            eof_q  <= eof1_q;
            if (v1_q) pxl_q <= mem_rdata;
            done_q <= (state_q == S_DRAIN) && eof_q;
        end
    end

endmodule

// File: tb/tb_pxl_stream_tx.sv
// Directed bench for pxl_stream_tx at D=4: one instance with GAP=0, one with GAP=2.
module tb_pxl_stream_tx;

    localparam int D  = 4;
    localparam int N  = 16;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic sel   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] ram [N];

    logic          start0, start2;
    logic          en0, en2, v0, v2, sof0, sof2, eol0, eol2, eof0, eof2;
    logic          busy0, busy2, done0, done2;
    logic [AW-1:0] addr0, addr2;
    logic [DW-1:0] rd0, rd2, pxl0, pxl2;
    logic [1:0]    st0, st2;

    logic          o_en, o_v, o_sof, o_eol, o_eof, o_busy, o_done;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_pxl;
    logic [1:0]    o_st;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    assign start0 = start & ~sel;
    assign start2 = start & sel;

    pxl_stream_tx #(.D(D), .data_width(DW), .ADDR_W(AW), .GAP(0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .pause(pause),
        .mem_en(en0), .mem_addr(addr0), .mem_rdata(rd0),
        .valid_out(v0), .pxl_out(pxl0), .sof(sof0), .eol(eol0), .eof(eof0),
        .busy(busy0), .done(done0), .state_o(st0)
    );

    pxl_stream_tx #(.D(D), .data_width(DW), .ADDR_W(AW), .GAP(2)) u2 (
        .clk(clk), .reset(reset), .start(start2), .pause(pause),
        .mem_en(en2), .mem_addr(addr2), .mem_rdata(rd2),
        .valid_out(v2), .pxl_out(pxl2), .sof(sof2), .eol(eol2), .eof(eof2),
        .busy(busy2), .done(done2), .state_o(st2)
    );

    always @(posedge clk) begin
        if (en0) rd0 <= ram[addr0];
        if (en2) rd2 <= ram[addr2];
    end

    assign o_en   = sel ? en2   : en0;
    assign o_addr = sel ? addr2 : addr0;
    assign o_v    = sel ? v2    : v0;
    assign o_pxl  = sel ? pxl2  : pxl0;
    assign o_sof  = sel ? sof2  : sof0;
    assign o_eol  = sel ? eol2  : eol0;
    assign o_eof  = sel ? eof2  : eof0;
    assign o_busy = sel ? busy2 : busy0;
    assign o_done = sel ? done2 : done0;
    assign o_st   = sel ? st2   : st0;

    function automatic logic [DW-1:0] pix(input int k);
        return 32'h3F80_0000 + 32'(k) * 32'h0001_0101;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame on the selected instance and checks every cycle against
    // an issue-time model. With cont=1 the current cycle is already frame cycle 0.
    task automatic run_frame(input int g, input int ps, input int pl, input bit hold,
                             input bit cont, input int exp_span, input string nm);
        int iss[N];
        int t, ki, bi, last, first_v, last_v;
        logic exp_en, exp_v;
        logic [DW-1:0] last_pxl, exp_w;
        t = 1;
        for (int k = 0; k < N; k++) begin
            while (t >= ps && t < ps + pl) t++;
            iss[k] = t;
            t++;
            if ((k % D) == D - 1 && k < N - 1) t += g;
        end
        last = iss[N-1] + 2;
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(pix(k));
        if (!cont) begin
            @(negedge clk);
            start = 1'b1;
            #1;
        end
        last_pxl = o_pxl;
        ki = 0; bi = 0; first_v = -1; last_v = -1;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            pause = (c >= ps && c < ps + pl);
            start = hold;
            #1;
            exp_en = (ki < N) && (iss[ki] == c);
            chk({nm, " mem_en"}, 64'(o_en), 64'(exp_en));
            if (exp_en) begin
                chk({nm, " mem_addr"}, 64'(o_addr), 64'(ki));
                ki++;
            end
            chk({nm, " busy"}, 64'(o_busy), 64'(c <= last));
            chk({nm, " done"}, 64'(o_done), 64'(c == last + 1));
            exp_v = (bi < N) && (iss[bi] + 2 == c);
            chk({nm, " valid_out"}, 64'(o_v), 64'(exp_v));
            if (exp_v) begin
                exp_w = exp_q.pop_front();
                chk({nm, " pxl_out"}, 64'(o_pxl), 64'(exp_w));
                chk({nm, " flags"}, 64'({o_sof, o_eol, o_eof}),
                    64'({bi == 0, (bi % D) == D - 1, bi == N - 1}));
                last_pxl = exp_w;
                if (first_v < 0) first_v = c;
                last_v = c;
                bi++;
            end else begin
                chk({nm, " idle flags"}, 64'({o_sof, o_eol, o_eof}), 64'(0));
                chk({nm, " idle pxl hold"}, 64'(o_pxl), 64'(last_pxl));
            end
        end
        pause = 1'b0;
        chk({nm, " beat count"}, 64'(bi), 64'(N));
        chk({nm, " span"}, 64'(last_v - first_v + 1), 64'(exp_span));
    endtask

    initial begin
        for (int k = 0; k < N; k++) ram[k] = pix(k);
        rd0 = '0;
        rd2 = '0;

        repeat (3) @(negedge clk);
        #1;
        sel = 1'b0;
        #1;
        chk("reset state u0", 64'({o_en, o_addr, o_v, o_pxl, o_sof, o_eol, o_eof, o_busy, o_done, o_st}), 64'(0));
        sel = 1'b1;
        #1;
        chk("reset state u2", 64'({o_en, o_addr, o_v, o_pxl, o_sof, o_eol, o_eof, o_busy, o_done, o_st}), 64'(0));
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_frame(0, 0, 0, 1'b0, 1'b0, 16, "f0_plain");
        run_frame(0, 7, 3, 1'b0, 1'b0, 19, "f0_pause_mid");
        run_frame(0, 4, 2, 1'b0, 1'b0, 18, "f0_pause_eol");

        sel = 1'b1;
        run_frame(2, 0, 0, 1'b0, 1'b0, 22, "f2_plain");
        run_frame(2, 5, 2, 1'b0, 1'b0, 22, "f2_pause_gap");
        sel = 1'b0;

        // abort during row 2: beat 7 is on the output in cycle 10
        @(negedge clk);
        start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("abort pre valid", 64'(o_v), 64'(1));
        chk("abort pre pxl", 64'(o_pxl), 64'(pix(7)));
        #2;
        reset = 1'b0;
        #1;
        chk("abort async clear", 64'({o_en, o_addr, o_v, o_pxl, o_sof, o_eol, o_eof, o_busy, o_done, o_st}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            chk("abort quiet", 64'({o_v, o_done, o_busy, o_en}), 64'(0));
        end
        run_frame(0, 0, 0, 1'b0, 1'b0, 16, "f0_after_abort");

        run_frame(0, 0, 0, 1'b1, 1'b0, 16, "b2b_a");
        run_frame(0, 0, 0, 1'b1, 1'b1, 16, "b2b_b");
        run_frame(0, 0, 0, 1'b0, 1'b1, 16, "b2b_c");
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("post b2b idle", 64'({o_v, o_busy, o_en}), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
